// File: rtl/adaptive_binarise_pkg.sv
// Shared helpers for adaptive_colour_binarise.
// Build option: ADAPTIVE_BINARISE_HYSTERESIS_EN selects hysteresis compare.
package adaptive_binarise_pkg;

    localparam int DEF_DEPTH  = 8;
    localparam int DEF_WINDOW = 1024;

    // Power-on threshold: half of full scale.
    function automatic int unsigned midscale(input int unsigned depth);
        return 32'd1 << (depth - 1);
    endfunction

    // Counter width for a power-of-two window.
    function automatic int win_bits(input int window);
        return $clog2(window);
    endfunction

    // A full window of full-scale samples fits exactly in this width.
    function automatic int sum_width(input int depth, input int window);
        return depth + win_bits(window);
    endfunction

    // LSB position of channel c inside the packed pixel.
    function automatic int chan_lsb(input int c, input int depth);
        return c * depth;
    endfunction

    // Sum type for the default build; modules derive their own from params.
    typedef logic [sum_width(DEF_DEPTH, DEF_WINDOW)-1:0] sum_def_t;

endpackage

// File: rtl/adaptive_colour_binarise_channel_accumulator.sv
// One channel: window sum, threshold register and binarising compare.
// Build option: ADAPTIVE_BINARISE_HYSTERESIS_EN adds a +/-HYST hold band.
module channel_accumulator
    import adaptive_binarise_pkg::*;
#(
    parameter int COLOUR_DEPTH = 8,
    parameter int WINDOW       = 1024,
    parameter int HYST         = 4
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    i_sof,
    input  logic                    i_valid,
    input  logic                    i_win_end,
    input  logic [COLOUR_DEPTH-1:0] i_pix,
    output logic                    o_bin
);

    localparam int WB    = win_bits(WINDOW);
    localparam int SUM_W = sum_width(COLOUR_DEPTH, WINDOW);

    typedef logic [SUM_W-1:0]        sum_t;
    typedef logic [COLOUR_DEPTH-1:0] chan_t;

    localparam chan_t MID = chan_t'(midscale(COLOUR_DEPTH));

    if (HYST < 0 || HYST >= (1 << COLOUR_DEPTH)) begin : g_bad_hyst
        $error("HYST must be in [0, 2^COLOUR_DEPTH)");
    end

    sum_t  r_sum;
    chan_t r_thresh;
    logic  r_bin;
    sum_t  w_total;
    logic  w_bin_next;
    logic  w_unused;

    assign w_total  = r_sum + sum_t'(i_pix);
    // Fraction bits of the average are dropped.
    assign w_unused = ^w_total[WB-1:0];

    // Window sum; the closing pixel is folded into the new threshold.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sum    <= '0;
            r_thresh <= MID;
        end else if (i_sof) begin
            r_sum <= i_valid ? sum_t'(i_pix) : '0;
        end else if (i_valid) begin
            if (i_win_end) begin
                r_sum    <= '0;
                r_thresh <= w_total[SUM_W-1:WB];
            end else begin
                r_sum <= w_total;
            end
        end
    end

`ifdef ADAPTIVE_BINARISE_HYSTERESIS_EN
    localparam logic [COLOUR_DEPTH:0] MAXV   = {1'b0, {COLOUR_DEPTH{1'b1}}};
    localparam logic [COLOUR_DEPTH:0] HYST_V = (COLOUR_DEPTH + 1)'(HYST);

    logic [COLOUR_DEPTH:0] w_hi_ext;
    chan_t                 w_hi;
    chan_t                 w_lo;

    assign w_hi_ext = {1'b0, r_thresh} + HYST_V;
    assign w_hi = (w_hi_ext > MAXV) ? '1 : w_hi_ext[COLOUR_DEPTH-1:0];
    assign w_lo = ({1'b0, r_thresh} < HYST_V) ? '0
                : chan_t'({1'b0, r_thresh} - HYST_V);

    // Outside the band follow the pixel; inside it keep the last bit.
    always_comb begin
        w_bin_next = r_bin;
        if (i_pix > w_hi) begin
            w_bin_next = 1'b1;
        end else if (i_pix < w_lo) begin
            w_bin_next = 1'b0;
        end
    end
`else
    assign w_bin_next = (i_pix > r_thresh);
`endif

    // Registered decision; held while no valid pixel arrives.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_bin <= 1'b0;
        end else if (i_valid) begin
            r_bin <= w_bin_next;
        end
    end

    assign o_bin = r_bin;

endmodule

// File: rtl/adaptive_colour_binarise.sv
// Per-channel adaptive binariser: window counter and frame control.
// Build option: ADAPTIVE_BINARISE_HYSTERESIS_EN (hysteresis compare).
module adaptive_colour_binarise
    import adaptive_binarise_pkg::*;
#(
    parameter int CHANNELS     = 3,
    parameter int COLOUR_DEPTH = 8,
    parameter int WINDOW       = 1024,
    parameter int HYST         = 4
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             pix_valid_in,
    input  logic                             sof_in,
    input  logic [CHANNELS*COLOUR_DEPTH-1:0] pix_in,
    output logic                             bin_valid_out,
    output logic [CHANNELS-1:0]              bin_out,
    output logic                             thresh_update_out
);

    if (WINDOW < 2 || (WINDOW & (WINDOW - 1)) != 0) begin : g_bad_window
        $error("WINDOW must be a power of two and at least 2");
    end

    localparam int WB = win_bits(WINDOW);

    typedef logic [WB-1:0] cnt_t;

    localparam cnt_t LAST = cnt_t'(WINDOW - 1);

    cnt_t                r_cnt;
    logic                r_bin_valid;
    logic                r_update;
    logic                w_win_end;
    logic [CHANNELS-1:0] w_bin;

    // Start of frame discards the window, even on its last pixel.
    assign w_win_end = pix_valid_in && !sof_in && (r_cnt == LAST);

    // Window position, output valid tag and reload pulse.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt       <= '0;
            r_bin_valid <= 1'b0;
            r_update    <= 1'b0;
        end else begin
            r_bin_valid <= pix_valid_in;
            r_update    <= w_win_end;
            if (sof_in) begin
                r_cnt <= pix_valid_in ? cnt_t'(1) : '0;
            end else if (pix_valid_in) begin
                r_cnt <= r_cnt + cnt_t'(1);
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        channel_accumulator #(
            .COLOUR_DEPTH (COLOUR_DEPTH),
            .WINDOW       (WINDOW),
            .HYST         (HYST)
        ) u_acc (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .i_sof     (sof_in),
            .i_valid   (pix_valid_in),
            .i_win_end (w_win_end),
            .i_pix     (pix_in[chan_lsb(c, COLOUR_DEPTH) +: COLOUR_DEPTH]),
            .o_bin     (w_bin[c])
        );
    end

    assign bin_valid_out     = r_bin_valid;
    assign bin_out           = w_bin;
    assign thresh_update_out = r_update;

endmodule

// File: tb/tb_adaptive_colour_binarise.sv
// Directed bench for adaptive_colour_binarise (3 ch, 8 bit, window 4).
// Expected hysteresis results follow ADAPTIVE_BINARISE_HYSTERESIS_EN.
module tb_adaptive_colour_binarise;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vld = 1'b0;
    logic        sof = 1'b0;
    logic [23:0] pix = '0;
    logic        bv;
    logic [2:0]  bin;
    logic        upd;

    int n_cmp = 0;
    int n_bad = 0;

    adaptive_colour_binarise #(
        .CHANNELS     (3),
        .COLOUR_DEPTH (8),
        .WINDOW       (4),
        .HYST         (4)
    ) dut (
        .clk_in            (clk),
        .rst_in            (rst),
        .pix_valid_in      (vld),
        .sof_in            (sof),
        .pix_in            (pix),
        .bin_valid_out     (bv),
        .bin_out           (bin),
        .thresh_update_out (upd)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      nm;
        logic       rst;
        logic       vld;
        logic       sof;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [7:0] p2;
        logic       ebv;
        logic [2:0] ebin;
        logic       eupd;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string nm, input logic r, input logic v,
                       input logic s, input int a, input int b, input int c,
                       input logic ebv, input logic [2:0] ebin,
                       input logic eupd);
        vec_t t;
        t.nm   = nm;
        t.rst  = r;
        t.vld  = v;
        t.sof  = s;
        t.p0   = 8'(a);
        t.p1   = 8'(b);
        t.p2   = 8'(c);
        t.ebv  = ebv;
        t.ebin = ebin;
        t.eupd = eupd;
        tbl.push_back(t);
    endtask

    task automatic check(input string nm, input logic [2:0] act,
                         input logic [2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // Drive one cycle, then sample 1 ns after the edge.
    task automatic apply(input string nm, input logic r, input logic v,
                         input logic s, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] c,
                         input logic ebv, input logic [2:0] ebin,
                         input logic eupd);
        rst = r;
        vld = v;
        sof = s;
        pix = {c, b, a};
        @(posedge clk);
        #1;
        check({nm, ".valid"}, {2'b0, bv}, {2'b0, ebv});
        check({nm, ".bin"}, bin, ebin);
        check({nm, ".upd"}, {2'b0, upd}, {2'b0, eupd});
    endtask

    initial begin
        // reset state, first pixel against midscale
        add("rst0",   1, 0, 0,   0,   0,   0, 0, 3'b000, 0);
        add("rst1",   1, 0, 0,   0,   0,   0, 0, 3'b000, 0);
        add("first",  0, 1, 0, 200,  50, 128, 1, 3'b001, 0);
        add("rst2",   1, 0, 0,   0,   0,   0, 0, 3'b000, 0);
        // window A against 128 -> thresholds (25,100,128)
        add("wa1",    0, 1, 0,  10, 100, 255, 1, 3'b100, 0);
        add("wa2",    0, 1, 0,  20, 200,   0, 1, 3'b010, 0);
        add("wa3",    0, 1, 0,  30,  60, 130, 1, 3'b100, 0);
        add("wa4",    0, 1, 0,  40,  40, 127, 1, 3'b000, 1);
        add("ta1",    0, 1, 0,  26, 101, 129, 1, 3'b111, 0);
        add("ta2",    0, 1, 0,  25, 101, 128, 1, 3'b010, 0);
        add("sofidl", 0, 0, 1,   0,   0,   0, 0, 3'b010, 0);
        // same window with gaps -> same thresholds
        add("wg1",    0, 1, 0,  10, 100, 255, 1, 3'b100, 0);
        add("gap1",   0, 0, 0, 255, 255, 255, 0, 3'b100, 0);
        add("wg2",    0, 1, 0,  20, 200,   0, 1, 3'b010, 0);
        add("gap2",   0, 0, 0,   0,   0,   0, 0, 3'b010, 0);
        add("wg3",    0, 1, 0,  30,  60, 130, 1, 3'b101, 0);
        add("gap3",   0, 0, 0,   0,   0,   0, 0, 3'b101, 0);
        add("wg4",    0, 1, 0,  40,  40, 127, 1, 3'b001, 1);
        add("tg1",    0, 1, 0,  26, 100, 129, 1, 3'b101, 0);
        add("tg2",    0, 1, 0,  25, 101, 128, 1, 3'b010, 0);
        add("wc3",    0, 1, 0,   0,   0,   0, 1, 3'b000, 0);
        // sof on what would be the window end: no reload
        add("sofend", 0, 1, 1,   0,   0,   0, 1, 3'b000, 0);
        add("ws2",    0, 1, 0, 100, 100, 100, 1, 3'b001, 0);
        add("ws3",    0, 1, 0, 100, 100, 100, 1, 3'b001, 0);
        add("ws4",    0, 1, 0, 100, 100, 100, 1, 3'b001, 1);
        add("ts1",    0, 1, 0,  76,  75,  76, 1, 3'b101, 0);
        add("ts2",    0, 1, 0,  75,  76,  75, 1, 3'b010, 0);
        // reset mid-window beats sof and valid
        add("rstmid", 1, 1, 1, 255, 255, 255, 0, 3'b000, 0);
        add("wr1",    0, 1, 0, 129, 128, 200, 1, 3'b101, 0);
        add("wr2",    0, 1, 0, 128, 129,   0, 1, 3'b010, 0);
        add("wr3",    0, 1, 0,   0,   0,   0, 1, 3'b000, 0);
        add("wr4",    0, 1, 0,   4,   0,   0, 1, 3'b000, 1);
        add("tr1",    0, 1, 0,  66,  64,  51, 1, 3'b101, 0);
        add("tr2",    0, 1, 0,  65,  65,  50, 1, 3'b010, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].nm, tbl[i].rst, tbl[i].vld, tbl[i].sof,
                  tbl[i].p0, tbl[i].p1, tbl[i].p2,
                  tbl[i].ebv, tbl[i].ebin, tbl[i].eupd);
        end

        // band around midscale: 133,130,126,123 on channel 0
        apply("hrst", 1, 0, 0, 0, 0, 0, 0, 3'b000, 0);
        apply("h133", 0, 1, 0, 133, 0, 0, 1, 3'b001, 0);
        apply("h130", 0, 1, 0, 130, 0, 0, 1, 3'b001, 0);
`ifdef ADAPTIVE_BINARISE_HYSTERESIS_EN
        apply("h126", 0, 1, 0, 126, 0, 0, 1, 3'b001, 0);
`else
        apply("h126", 0, 1, 0, 126, 0, 0, 1, 3'b000, 0);
`endif
        apply("h123", 0, 1, 0, 123, 0, 0, 1, 3'b000, 1);
        apply("hidle", 0, 0, 0, 0, 0, 0, 0, 3'b000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/adaptive_colour_binarise.md
Name: adaptive_colour_binarise

Overview:
- Per-channel adaptive thresholding of a streaming pixel bus. Each channel compares against its running window average and produces one bit, so a CHANNELS x COLOUR_DEPTH pixel becomes CHANNELS bits.
- Sits between the camera pixel stream and marker detection. It is the parametrised successor of the fixed 3-channel compressor.
- Adds over that compressor:
  - valid qualification
  - frame-start window restart
  - programmable window size
  - synchronous reset
  - a registered, valid-tagged output

Parameters:
- CHANNELS, 3, number of colour channels packed in pix_in; channel 0 in the LSBs.
- COLOUR_DEPTH, 8, bits per channel.
- WINDOW, 1024, valid pixels per averaging window. Must be a power of two and at least 2; elaborate-time error otherwise.
- HYST, 4, hysteresis half-band in LSBs. Used only when the optional feature is compiled in.

Ports:
- clk_in  in  1  pixel clock; all logic rising-edge.
- rst_in  in  1  synchronous, active-high reset.
- pix_valid_in  in  1  pix_in carries a valid pixel this cycle.
- sof_in  in  1  start of frame; restarts the averaging window.
- pix_in  in  CHANNELS*COLOUR_DEPTH  packed pixel.
- bin_valid_out  out  1  bin_out valid; pix_valid_in delayed by 1 cycle.
- bin_out  out  CHANNELS  bit c = 1 when channel c is above its threshold.
- thresh_update_out  out  1  one-cycle pulse when thresholds are reloaded.

Behaviour:
- Reset (rst_in=1 at a clock edge):
  - bin_valid_out=0, bin_out=0, thresh_update_out=0.
  - Window counter=0; all sums=0.
  - All thresholds = 2^(COLOUR_DEPTH-1) (midscale, 128 at default).
  - Reset mid-window discards the partial sums.
- Widths:
  - WIN_BITS = clog2(WINDOW).
  - Sum width = COLOUR_DEPTH+WIN_BITS; cannot overflow.
  - Counter width = WIN_BITS; wraps naturally.
- Accumulate: each cycle with pix_valid_in=1, sum[c] += channel c and counter += 1.
- Window end, when pix_valid_in=1 and counter==WINDOW-1:
  - That pixel is included in the average.
  - Next edge: thresh[c] <= (sum[c]+pixel[c]) >> WIN_BITS, sums cleared, counter wraps to 0, thresh_update_out=1 for one cycle.
- Threshold usage: the pixel that closes a window is compared against the old thresholds. New thresholds apply from the following valid pixel onward.
- Compare: bin_out[c] <= (pixel[c] > thresh[c]), strictly greater, registered.
  - Latency 1 cycle; bin_valid_out <= pix_valid_in.
  - When pix_valid_in=0, bin_out holds its previous value.
- sof_in=1:
  - Counter and sums cleared; thresholds are NOT updated (partial window discarded, no update pulse).
  - If pix_valid_in=1 in the same cycle, that pixel becomes the first sample of the new window and is still binarised.
  - If sof_in coincides with a window end, sof_in wins: no threshold update.
- rst_in has priority over sof_in and pix_valid_in.
- No backpressure; the block accepts one pixel per cycle continuously.

Optional Feature:
- Macro: ADAPTIVE_BINARISE_HYSTERESIS_EN.
- Defined: per channel, output bit becomes 1 when pixel > thresh+HYST and 0 when pixel < thresh-HYST. Inside the band it holds the last output for that channel.
  - The band is computed with saturation at 0 and 2^COLOUR_DEPTH-1.
  - Reset clears the held state to 0.
- Undefined: plain strict compare; HYST is unused.

Decomposition:
- Shared package adaptive_binarise_pkg:
  - midscale constant function
  - WIN_BITS helper via clog2
  - channel-slice helper function
  - typedef for sum width given depth and window
- Sub-module channel_accumulator, instantiated CHANNELS times via generate:
  - owns one sum, threshold, compare and hysteresis state
  - the window counter and sof/end control remain in the top level.

Test Plan (bench uses CHANNELS=3, COLOUR_DEPTH=8, WINDOW=4):
- Reset, then pixel (200,50,128) valid -> 1 cycle later bin_valid_out=1, bin_out=3'b001. Thresholds are 128, and 128 is not greater than 128.
- 4 valid pixels with ch0 = 10,20,30,40 -> thresh_update_out pulses the cycle after the 4th pixel. Ch0 threshold becomes 25: next pixel 26 gives bit0=1, 25 gives bit0=0.
- Valid gaps: same 4 pixels with pix_valid_in low between them -> identical threshold 25. bin_out holds during gaps; bin_valid_out low during gaps.
- 3 valid pixels, then sof_in with valid pixel 0 -> no update pulse, thresholds stay 128. The window restarts and completes 3 pixels later.
- rst_in asserted after 2 pixels of a window with thresh=25 -> thresholds return to 128, all outputs 0, next window starts counting from 0.
- With ADAPTIVE_BINARISE_HYSTERESIS_EN and HYST=4, thresh=128: ch0 sequence 133,130,126,123 -> bit0 = 1,1,1,0. Without the macro -> 1,1,0,0.
